uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver for serial host links. Data width, parity and stop-bit count are compile-time configurable, and the block reports framing, parity and break errors. It sits between the synchronised RX pad and the byte-level consumer, which is typically a command parser or a FIFO in front of the hashing core. Output is one strobe per received character.

## Interface
- CLKS_PER_BIT, 868: i_Clock cycles per bit (clock freq / baud); must be ≥ 4.
- DATA_BITS, 8: data bits per character, 5..9, LSB first.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even. Honoured only with UART_RX_PARITY_EN.
- STOP_BITS, 1: 1 or 2.
- i_Clock  in  1  single clock, rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line, idle high.
- o_Rx_DV  out  1  one-cycle strobe; character and flags valid.
- o_Rx_Byte  out  DATA_BITS  last received character, held until next o_Rx_DV.
- o_Frame_Err  out  1  a stop bit sampled low; valid with o_Rx_DV, held.
- o_Parity_Err  out  1  parity mismatch; valid with o_Rx_DV, held.
- o_Break  out  1  whole frame sampled low; valid with o_Rx_DV, held.
- o_Busy  out  1  high in every state except IDLE.

## Operation
- i_Rx_Serial passes through a 2-flop synchroniser (reset value 1). The FSM sees only the synchronised value.
- States are IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH. The counter is $clog2(CLKS_PER_BIT) bits wide; H = (CLKS_PER_BIT-1)/2.
- **IDLE:** counter and bit index are cleared. A low synchronised line moves the FSM to START.
- **START:** counts 0..H. At H:
  - line still low → DATA, counter cleared;
  - line high → IDLE (glitch rejected, no strobe).
- **DATA:** at counter = CLKS_PER_BIT-1, sample the line into o_Rx_Byte[index] and clear the counter. After the sample for index DATA_BITS-1, go to PARITY if enabled, else STOP.
- **PARITY:** same timing. Sample one bit and compare it to the XOR of the data bits (odd: expect XOR inverted; even: expect XOR).
- **STOP:** same timing, repeated STOP_BITS times. Any low sample sets the frame error.
- **DONE:** one cycle. Assert o_Rx_DV and update the three flags. Then:
  - if break → WAIT_HIGH;
  - otherwise → IDLE.
- **Break condition:** all data bits, the parity bit (if present) and every stop bit are 0. A break also sets o_Frame_Err. o_Rx_Byte = 0.
- **WAIT_HIGH:** stay until the synchronised line is high, then go to IDLE. No strobe is issued while the line stays low.
- A new start bit is accepted from the cycle after DONE. Because stop is sampled mid-bit, the receiver has a half-bit of margin against fast transmitters.

## Timing
- Reset values: o_Rx_DV = 0, o_Rx_Byte = 0, all flags = 0, o_Busy = 0; FSM in IDLE; synchroniser at 1.
- Synchronisation delay: 2 cycles from the pin to the FSM.
- With F = 1 + DATA_BITS + parity(0/1) + STOP_BITS:
  - the final stop sample lands H + 1 + (F-1)·CLKS_PER_BIT cycles after START entry;
  - o_Rx_DV is high on the next cycle, for exactly 1 cycle.
- o_Rx_Byte and the flags change only on the o_Rx_DV cycle.
- i_Reset has priority in every state. Mid-frame reset aborts the frame with no strobe, and all outputs return to reset values on the next edge.

## Configuration
- Macro: UART_RX_PARITY_EN.
- **Defined:** the PARITY state exists and PARITY_MODE 1/2 inserts a parity bit.
- **Undefined:** the PARITY state and XOR logic are not compiled, PARITY_MODE is ignored (the frame has no parity bit), and o_Parity_Err is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - state encodings (3-bit);
  - PARITY_NONE/ODD/EVEN constants;
  - a function computing F from the parameters.
- Sub-module uart_rx_sync: 2-flop synchroniser with synchronous reset-to-1. Reused by future UART blocks.

## Test plan
- CLKS_PER_BIT = 16, 8N1, send 0xA5 → one o_Rx_DV, o_Rx_Byte = 0xA5, all flags 0, strobe at the cycle count given in Timing.
- UART_RX_PARITY_EN defined, DATA_BITS = 7, even parity, send 0x41 with parity bit 1 (wrong) → o_Rx_Byte = 0x41, o_Parity_Err = 1. Resend with the correct bit (0) → flag clears.
- 8N2, second stop bit driven low → o_Frame_Err = 1, byte still delivered; the following good frame clears the flag.
- Hold the line low for 2 frame times, then high → exactly one o_Rx_DV with o_Break = 1, o_Frame_Err = 1, byte 0x00. No further strobe until the next real start bit.
- Low glitch of H-1 cycles → no o_Rx_DV, o_Busy returns to 0. Assert i_Reset during data bit 3 → no strobe, outputs at reset values, and the next frame is received correctly.
- UART_RX_PARITY_EN undefined with PARITY_MODE = 2, send 0x3C as an 8N1 frame → received correctly, o_Parity_Err constant 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity constants and frame-length helper (honours UART_RX_PARITY_EN)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_BUILD = 1'b1;
`else
  localparam bit PARITY_BUILD = 1'b0;
`endif

  // Bits per character: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity_mode, input int stop_bits);
    int par;
    par = (PARITY_BUILD && (parity_mode == PARITY_ODD || parity_mode == PARITY_EVEN)) ? 1 : 0;
    return 1 + data_bits + par + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an idle-high asynchronous input
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic [1:0] r_meta;

  // Shift the pad through two flops; reset to the idle (high) level.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_meta <= 2'b11;
    else         r_meta <= {r_meta[0], i_Async};
  end

  assign o_Sync = r_meta[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with frame/parity/break flags (parity via UART_RX_PARITY_EN)
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = 4;
  localparam int F     = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
  localparam logic [CNT_W-1:0] H_CNT   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(F - 2);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = (PARITY_MODE == PARITY_ODD) || (PARITY_MODE == PARITY_EVEN);
`endif

  uart_state_t          r_state, w_next;
  logic                 w_rx;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;   // samples taken since the start bit
  logic [DATA_BITS-1:0] r_data;
  logic                 r_all_low;
  logic                 r_stop_err;
  logic [DATA_BITS-1:0] r_byte;
  logic                 r_frame_err, r_parity_err, r_break;
  logic                 w_tick, w_last_stop, w_par_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
`endif

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (w_rx)
  );

  assign w_tick      = (r_cnt == LAST_CNT);
  assign w_last_stop = (r_state == ST_STOP) && w_tick && (r_idx == LAST_STOP);

`ifdef UART_RX_PARITY_EN
  assign w_par_err = PAR_EN &&
                     (r_par_bit != ((PARITY_MODE == PARITY_ODD) ? ~(^r_data) : (^r_data)));
`else
  assign w_par_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_rx) w_next = ST_START;
      ST_START: if (r_cnt == H_CNT) w_next = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_tick && r_idx == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
        w_next = PAR_EN ? ST_PARITY : ST_STOP;
`else
        w_next = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (w_tick) w_next = ST_STOP;
`endif
      ST_STOP:      if (w_last_stop) w_next = ST_DONE;
      ST_DONE:      w_next = r_break ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (w_rx) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Bit timing, sampling and result registers; results load on the final stop sample.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_data       <= '0;
      r_all_low    <= 1'b1;
      r_stop_err   <= 1'b0;
      r_byte       <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_break      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt      <= '0;
          r_idx      <= '0;
          r_all_low  <= 1'b1;
          r_stop_err <= 1'b0;
        end
        ST_START: r_cnt <= (r_cnt == H_CNT) ? '0 : r_cnt + 1'b1;
        ST_DATA, ST_PARITY, ST_STOP: begin
          if (w_tick) begin
            r_cnt     <= '0;
            r_idx     <= r_idx + 1'b1;
            r_all_low <= r_all_low & ~w_rx;
            if (r_state == ST_DATA) r_data <= {w_rx, r_data[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
            if (r_state == ST_PARITY) r_par_bit <= w_rx;
`endif
            if (r_state == ST_STOP && !w_rx) r_stop_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_last_stop) begin
            r_byte       <= r_data;
            r_frame_err  <= r_stop_err | ~w_rx;
            r_parity_err <= w_par_err;
            r_break      <= r_all_low & ~w_rx;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_Rx_DV      = (r_state == ST_DONE);
  assign o_Busy       = (r_state != ST_IDLE);
  assign o_Rx_Byte    = r_byte;
  assign o_Frame_Err  = r_frame_err;
  assign o_Parity_Err = r_parity_err;
  assign o_Break      = r_break;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg (UART_RX_PARITY_EN selects the parity cases)
module tb_uart_rx_cfg;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int C_BITS = 7;
`else
  localparam int C_BITS = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic dv_a, dv_b, dv_c;
  logic [7:0] byte_a, byte_b;
  logic [C_BITS-1:0] byte_c;
  logic fe_a, fe_b, fe_c, pe_a, pe_b, pe_c, brk_a, brk_b, brk_c, busy_a, busy_b, busy_c;

  int cyc = 0;
  int n_checks = 0, n_pass = 0;
  int dv_cnt_a = 0, dv_cnt_b = 0, dv_cnt_c = 0;
  int dv_cyc_a = 0;
  int t_send = 0;
  int base;
  bit pe_seen_c = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
    .o_Frame_Err(fe_a), .o_Parity_Err(pe_a), .o_Break(brk_a), .o_Busy(busy_a));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
    .o_Frame_Err(fe_b), .o_Parity_Err(pe_b), .o_Break(brk_b), .o_Busy(busy_b));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(C_BITS), .PARITY_MODE(2), .STOP_BITS(1)) dut_c (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_c), .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c),
    .o_Frame_Err(fe_c), .o_Parity_Err(pe_c), .o_Break(brk_c), .o_Busy(busy_c));

  // Strobe monitor: counts o_Rx_DV pulses and records when they occur.
  always @(negedge clk) begin
    if (dv_a) begin dv_cnt_a++; dv_cyc_a = cyc; end
    if (dv_b) dv_cnt_b++;
    if (dv_c) dv_cnt_c++;
    if (pe_c) pe_seen_c = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Drive one bit for a full bit period, starting at a falling edge.
  task automatic drive_bit(input int sel, input logic v);
    set_line(sel, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input int has_par, input logic par_bit,
                            input int nstop, input logic [1:0] stop_v);
    @(negedge clk);
    t_send = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
    if (has_par != 0) drive_bit(sel, par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stop_v[i]);
    set_line(sel, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_dv", 32'(dv_a), 32'd0);
    check("reset_byte", 32'(byte_a), 32'd0);
    check("reset_flags", {29'd0, fe_a, pe_a, brk_a}, 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);

    // 8N1 0xA5: DV lands 2 (sync) + 1 (enter START) + H+1 + 9*CPB cycles after the start bit.
    base = dv_cnt_a;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
    check("a5_strobes", 32'(dv_cnt_a - base), 32'd1);
    check("a5_byte", 32'(byte_a), 32'hA5);
    check("a5_flags", {29'd0, fe_a, pe_a, brk_a}, 32'd0);
    check("a5_latency", 32'(dv_cyc_a - t_send), 32'd155);

    // Break: line low for two frame times, then released.
    base = dv_cnt_a;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (2 * 10 * CPB) @(negedge clk);
    rx_a = 1'b1;
    repeat (10) @(negedge clk);
    check("brk_strobes", 32'(dv_cnt_a - base), 32'd1);
    check("brk_flag", 32'(brk_a), 32'd1);
    check("brk_frame_err", 32'(fe_a), 32'd1);
    check("brk_byte", 32'(byte_a), 32'd0);
    check("brk_busy_after", 32'(busy_a), 32'd0);
    repeat (60) @(negedge clk);
    check("brk_no_extra", 32'(dv_cnt_a - base), 32'd1);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11);
    check("post_brk_byte", 32'(byte_a), 32'h5A);
    check("post_brk_flags", {29'd0, fe_a, pe_a, brk_a}, 32'd0);

    // Glitch of H-1 = 6 cycles is rejected at the mid-start check.
    base = dv_cnt_a;
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_hi", 32'(busy_a), 32'd1);
    @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_dv", 32'(dv_cnt_a - base), 32'd0);
    check("glitch_busy_lo", 32'(busy_a), 32'd0);

    // Reset during data bit 3 aborts the frame.
    base = dv_cnt_a;
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rx_a = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_byte", 32'(byte_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_flags", {28'd0, dv_a, fe_a, pe_a, brk_a}, 32'd0);
    repeat (200) @(negedge clk);
    check("rst_no_dv", 32'(dv_cnt_a - base), 32'd0);
    send_frame(0, 9'h081, 8, 0, 1'b0, 1, 2'b11);
    check("rst_next_byte", 32'(byte_a), 32'h81);
    check("rst_next_strobes", 32'(dv_cnt_a - base), 32'd1);

    // 8N2 with the second stop bit low.
    base = dv_cnt_b;
    send_frame(1, 9'h0C3, 8, 0, 1'b0, 2, 2'b01);
    check("n2_strobes", 32'(dv_cnt_b - base), 32'd1);
    check("n2_byte", 32'(byte_b), 32'hC3);
    check("n2_frame_err", 32'(fe_b), 32'd1);
    check("n2_break", 32'(brk_b), 32'd0);
    send_frame(1, 9'h096, 8, 0, 1'b0, 2, 2'b11);
    check("n2_good_byte", 32'(byte_b), 32'h96);
    check("n2_good_frame_err", 32'(fe_b), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 7E1 0x41 has two ones, so the even parity bit must be 0.
    base = dv_cnt_c;
    send_frame(2, 9'h041, 7, 1, 1'b1, 1, 2'b11);
    check("par_bad_byte", 32'(byte_c), 32'h41);
    check("par_bad_flag", 32'(pe_c), 32'd1);
    check("par_bad_frame", 32'(fe_c), 32'd0);
    send_frame(2, 9'h041, 7, 1, 1'b0, 1, 2'b11);
    check("par_good_flag", 32'(pe_c), 32'd0);
    check("par_strobes", 32'(dv_cnt_c - base), 32'd2);
`else
    // Parity support compiled out: PARITY_MODE=2 still yields an 8N1 frame.
    base = dv_cnt_c;
    send_frame(2, 9'h03C, 8, 0, 1'b0, 1, 2'b11);
    check("nopar_byte", 32'(byte_c), 32'h3C);
    check("nopar_frame", 32'(fe_c), 32'd0);
    send_frame(2, 9'h0C1, 8, 0, 1'b0, 1, 2'b11);
    check("nopar_byte2", 32'(byte_c), 32'hC1);
    check("nopar_strobes", 32'(dv_cnt_c - base), 32'd2);
    check("nopar_perr_never", 32'(pe_seen_c), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
